mem_bus_controller: RTL and testbench
=====================================

# mem_bus_controller

- Sits directly downstream of the CPU core's data-memory port.
- Accepts the CPU's single-outstanding read/write dispatches (addr, write_data, dispatch_read, dispatch_write) and routes each one either to a fixed-latency synchronous RAM or to a request/acknowledge MMIO peripheral port.
- Returns completion pulses and read data to the CPU.
- Guards against hung peripherals with a timeout.

## Interface
Parameters:
- ADDR_WIDTH, 16, CPU address width
- DATA_WIDTH, 8, data width
- RAM_LATENCY, 2, cycles from ram_en_out to valid ram_rdata_in; legal range ≥1
- MMIO_BASE, 16'hF000, addresses ≥ this go to MMIO, below go to RAM
- MMIO_TIMEOUT, 64, max cycles waiting for mmio_ack_in; legal range ≥1

Ports:
- clk_in  in  1  system clock; all logic on its rising edge
- rst_in  in  1  asynchronous, active-low reset
- addr_in  in  ADDR_WIDTH  CPU request address
- write_data_in  in  DATA_WIDTH  CPU write data
- dispatch_read_in  in  1  read request, sampled only when idle
- dispatch_write_in  in  1  write request, sampled only when idle
- busy_out  out  1  transaction in flight; dispatches are ignored while high
- read_data_out  out  DATA_WIDTH  data of the last completed read; held until the next read completes
- read_valid_out  out  1  one-cycle read-completion pulse
- write_done_out  out  1  one-cycle write-completion pulse
- bus_error_out  out  1  one-cycle pulse, coincident with the completion pulse, on MMIO timeout
- ram_addr_out  out  ADDR_WIDTH  RAM address
- ram_wdata_out  out  DATA_WIDTH  RAM write data
- ram_en_out  out  1  RAM access strobe
- ram_we_out  out  1  RAM write enable
- ram_rdata_in  in  DATA_WIDTH  RAM read data
- mmio_addr_out  out  ADDR_WIDTH  peripheral address
- mmio_wdata_out  out  DATA_WIDTH  peripheral write data
- mmio_req_out  out  1  peripheral request level
- mmio_we_out  out  1  peripheral write qualifier
- mmio_ack_in  in  1  peripheral acknowledge
- mmio_rdata_in  in  DATA_WIDTH  peripheral read data, valid when mmio_ack_in is high

## Operation
- States: IDLE, RAM_WR, RAM_RD, MMIO_WAIT.
- busy_out = (state != IDLE).
- All downstream outputs are registered or decoded from state only. There is no combinational path from dispatch_*_in to ram_*/mmio_* outputs.
- In IDLE, a dispatch latches addr_in, write_data_in and the direction.
  - If both dispatch_read_in and dispatch_write_in are high, the write wins and the read is dropped.
  - addr ≥ MMIO_BASE → MMIO_WAIT.
  - Otherwise, write → RAM_WR and read → RAM_RD.
- RAM_WR: ram_en_out=ram_we_out=1 for exactly one cycle, then → IDLE with write_done_out=1.
- RAM_RD:
  - ram_en_out=1, ram_we_out=0 for the first cycle only.
  - A latency counter then runs RAM_LATENCY cycles.
  - On the edge ending the cycle where ram_rdata_in is valid, capture ram_rdata_in into read_data_out and go → IDLE with read_valid_out=1.
- MMIO_WAIT:
  - mmio_req_out is held high, with latched mmio_addr_out, mmio_wdata_out and mmio_we_out.
  - The timeout counter starts at 0 on entry and increments each cycle.
  - On the edge where mmio_ack_in=1:
    - reads capture mmio_rdata_in into read_data_out;
    - drop mmio_req_out;
    - → IDLE with read_valid_out or write_done_out pulsed.
  - If the counter reaches MMIO_TIMEOUT−1 with no ack:
    - drop mmio_req_out and go → IDLE;
    - pulse bus_error_out together with the completion pulse;
    - reads return all-ones in read_data_out.
  - If ack and timeout occur on the same edge, ack wins and there is no error.
- mmio_ack_in is ignored outside MMIO_WAIT.
- ram_rdata_in is ignored outside the capture cycle.
- Reset asserted mid-operation:
  - takes effect immediately and asynchronously;
  - the transaction is abandoned with no completion pulse;
  - mmio_req_out drops.

## Timing
- Reset value of every output is 0, including read_data_out. Outputs stay 0 until the first clock edge after rst_in deasserts.
- A dispatch is sampled on edge 0. Cycle n means the cycle after edge n−1.
- RAM write:
  - strobe in cycle 1, busy_out=1;
  - write_done_out in cycle 2, busy_out=0.
- RAM read:
  - strobe in cycle 1;
  - read_valid_out in cycle 2+RAM_LATENCY (cycle 4 at the default).
- MMIO: mmio_req_out rises in cycle 1. If ack is sampled on edge k, completion occurs in cycle k+1.
- Timeout: mmio_req_out is high for exactly MMIO_TIMEOUT cycles. Completion follows in the next cycle.
- Completion cycles are IDLE, so a new dispatch is accepted in the same cycle as a done or valid pulse.
- Maximum throughput:
  - RAM writes: one per 2 cycles;
  - RAM reads: one per 2+RAM_LATENCY cycles.
- MMIO decode boundary:
  - MMIO_BASE−1 → RAM;
  - MMIO_BASE → MMIO;
  - all-ones address → MMIO.

## Test plan
- Reset, then write 0x5A to 0x0010 → ram_en_out=ram_we_out=1 with addr 0x0010 and data 0x5A in cycle 1, write_done_out=1 in cycle 2, busy_out high in cycle 1 only.
- Read 0x0010 with the RAM model returning 0x5A after 2 cycles → ram_en_out pulses only in cycle 1, read_valid_out=1 and read_data_out=0x5A in cycle 4, and a second read dispatched in cycle 4 is accepted.
- Read 0xF004 with ack after 3 cycles and mmio_rdata_in=0xC3 → mmio_req_out high for exactly 3 cycles, read_valid_out and read_data_out=0xC3 next cycle, bus_error_out=0.
- Write 0xEFFF vs 0xF000 → the first goes to RAM, the second to MMIO. A dispatch pulsed during busy_out is ignored, with no extra strobe.
- MMIO read with no ack, MMIO_TIMEOUT=64 → mmio_req_out high 64 cycles, then read_valid_out=bus_error_out=1 and read_data_out=0xFF. Repeat with ack in the final cycle → no error.
- Assert rst_in low during MMIO_WAIT → mmio_req_out and busy_out go to 0 immediately, and no completion pulse occurs after release.

Source files
------------

// File: rtl/mem_bus_controller_if.sv
// mem_bus_if: CPU dispatch, RAM and MMIO signals of the memory bus controller.
// The slave modport is the controller's view; master is the environment's.
interface mem_bus_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] write_data_in;
  logic                  dispatch_read_in;
  logic                  dispatch_write_in;
  logic                  busy_out;
  logic [DATA_WIDTH-1:0] read_data_out;
  logic                  read_valid_out;
  logic                  write_done_out;
  logic                  bus_error_out;
  logic [ADDR_WIDTH-1:0] ram_addr_out;
  logic [DATA_WIDTH-1:0] ram_wdata_out;
  logic                  ram_en_out;
  logic                  ram_we_out;
  logic [DATA_WIDTH-1:0] ram_rdata_in;
  logic [ADDR_WIDTH-1:0] mmio_addr_out;
  logic [DATA_WIDTH-1:0] mmio_wdata_out;
  logic                  mmio_req_out;
  logic                  mmio_we_out;
  logic                  mmio_ack_in;
  logic [DATA_WIDTH-1:0] mmio_rdata_in;

  modport slave (
    input  addr_in, write_data_in,
    input  dispatch_read_in, dispatch_write_in,
    output busy_out, read_data_out,
    output read_valid_out, write_done_out,
    output bus_error_out,
    output ram_addr_out, ram_wdata_out,
    output ram_en_out, ram_we_out,
    input  ram_rdata_in,
    output mmio_addr_out, mmio_wdata_out,
    output mmio_req_out, mmio_we_out,
    input  mmio_ack_in, mmio_rdata_in
  );

  modport master (
    output addr_in, write_data_in,
    output dispatch_read_in, dispatch_write_in,
    input  busy_out, read_data_out,
    input  read_valid_out, write_done_out,
    input  bus_error_out,
    input  ram_addr_out, ram_wdata_out,
    input  ram_en_out, ram_we_out,
    output ram_rdata_in,
    input  mmio_addr_out, mmio_wdata_out,
    input  mmio_req_out, mmio_we_out,
    output mmio_ack_in, mmio_rdata_in
  );
endinterface

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: routes single-outstanding CPU dispatches to a
// fixed-latency RAM or a req/ack MMIO port, with an MMIO timeout.
module mem_bus_controller #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_LATENCY  = 2,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE = 16'hF000,
  parameter int MMIO_TIMEOUT = 64
) (
  input logic      clk_in,
  input logic      rst_in,
  mem_bus_if.slave bus
);
  localparam int CMAX = (RAM_LATENCY > MMIO_TIMEOUT) ?
                        RAM_LATENCY : MMIO_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LAT_END = CW'(RAM_LATENCY);
  localparam logic [CW-1:0] TO_END  = CW'(MMIO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, RAM_WR, RAM_RD, MMIO_WAIT
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  we_q;
  logic [CW-1:0]         cnt;
  logic                  read_valid_q;
  logic                  write_done_q;
  logic                  bus_error_q;
  logic                  start;
  logic                  fin;
  logic                  err;

  assign start = (state == IDLE) &&
                 (bus.dispatch_read_in || bus.dispatch_write_in);

  always_comb begin
    state_d = state;
    fin     = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          priority case (1'b1)
            (bus.addr_in >= MMIO_BASE): state_d = MMIO_WAIT;
            bus.dispatch_write_in:      state_d = RAM_WR;
            default:                    state_d = RAM_RD;
          endcase
        end
      end
      RAM_WR: begin
        state_d = IDLE;
        fin     = 1'b1;
      end
      RAM_RD: begin
        if (cnt == LAT_END) begin
          state_d = IDLE;
          fin     = 1'b1;
        end
      end
      MMIO_WAIT: begin
        // ack on the timeout edge still counts as a clean completion
        if (bus.mmio_ack_in) begin
          state_d = IDLE;
          fin     = 1'b1;
        end else if (cnt == TO_END) begin
          state_d = IDLE;
          fin     = 1'b1;
          err     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      we_q         <= 1'b0;
      cnt          <= '0;
      read_valid_q <= 1'b0;
      write_done_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      read_valid_q <= fin && !we_q;
      write_done_q <= fin && we_q;
      bus_error_q  <= err;
      cnt <= (state == IDLE) ? '0 : cnt + CW'(1);
      if (start) begin
        addr_q  <= bus.addr_in;
        wdata_q <= bus.write_data_in;
        we_q    <= bus.dispatch_write_in;
      end
      if (fin && !we_q) begin
        if (err)
          rdata_q <= '1;
        else if (state == MMIO_WAIT)
          rdata_q <= bus.mmio_rdata_in;
        else
          rdata_q <= bus.ram_rdata_in;
      end
    end
  end

  assign bus.busy_out       = (state != IDLE);
  assign bus.read_data_out  = rdata_q;
  assign bus.read_valid_out = read_valid_q;
  assign bus.write_done_out = write_done_q;
  assign bus.bus_error_out  = bus_error_q;
  assign bus.ram_addr_out   = addr_q;
  assign bus.ram_wdata_out  = wdata_q;
  assign bus.ram_en_out     = (state == RAM_WR) ||
                              ((state == RAM_RD) && (cnt == '0));
  assign bus.ram_we_out     = (state == RAM_WR);
  assign bus.mmio_addr_out  = addr_q;
  assign bus.mmio_wdata_out = wdata_q;
  assign bus.mmio_req_out   = (state == MMIO_WAIT);
  assign bus.mmio_we_out    = (state == MMIO_WAIT) && we_q;
endmodule

// File: tb/tb_mem_bus_controller.sv
// tb_mem_bus_controller: scoreboard bench for mem_bus_controller
// with a 2-cycle RAM model and a scripted MMIO peripheral.
module tb_mem_bus_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct packed {
    logic       rd;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];

  mem_bus_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  mem_bus_controller #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .RAM_LATENCY(2),
    .MMIO_BASE(16'hF000),
    .MMIO_TIMEOUT(64)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] pipe0 = 8'h00;
  logic [7:0] pipe1 = 8'h00;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
  end

  always @(posedge clk) begin
    if (bus.ram_en_out && bus.ram_we_out)
      mem[bus.ram_addr_out[7:0]] <= bus.ram_wdata_out;
    pipe0 <= (bus.ram_en_out && !bus.ram_we_out) ?
             mem[bus.ram_addr_out[7:0]] : 8'h00;
    pipe1 <= pipe0;
  end
  assign bus.ram_rdata_in = pipe1;

  // scoreboard: every completion pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (bus.read_valid_out || bus.write_done_out)) begin
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_completion rv=%b wd=%b",
                 bus.read_valid_out, bus.write_done_out);
      end else begin
        e = sb.pop_front();
        if ({bus.read_valid_out, bus.write_done_out} !== {e.rd, !e.rd}) begin
          miscompares++;
          $display("FAIL sb_kind got rv/wd=%b%b want %b%b",
                   bus.read_valid_out, bus.write_done_out, e.rd, !e.rd);
        end
        vectors++;
        if (bus.bus_error_out !== e.err) begin
          miscompares++;
          $display("FAIL sb_error got %b want %b", bus.bus_error_out, e.err);
        end
        if (e.rd) begin
          vectors++;
          if (bus.read_data_out !== e.data) begin
            miscompares++;
            $display("FAIL sb_rdata got %h want %h",
                     bus.read_data_out, e.data);
          end
        end
      end
    end
  end

  task automatic dispatch(input logic w, input logic r,
                          input logic [15:0] a, input logic [7:0] d);
    bus.dispatch_write_in = w;
    bus.dispatch_read_in  = r;
    bus.addr_in           = a;
    bus.write_data_in     = d;
    @(negedge clk);
    bus.dispatch_write_in = 1'b0;
    bus.dispatch_read_in  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus.busy_out, bus.ram_en_out, bus.ram_we_out,
         bus.mmio_req_out, bus.mmio_we_out} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 00000",
               {bus.busy_out, bus.ram_en_out, bus.ram_we_out,
                bus.mmio_req_out, bus.mmio_we_out});
    end
    vectors++;
    if ({bus.read_valid_out, bus.write_done_out,
         bus.bus_error_out} !== 3'b0) begin
      miscompares++;
      $display("FAIL reset_pulses got %b want 000",
               {bus.read_valid_out, bus.write_done_out, bus.bus_error_out});
    end
    vectors++;
    if (bus.read_data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rdata got %h want 00", bus.read_data_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram_write();
    sb.push_back('{rd: 1'b0, data: 8'h00, err: 1'b0});
    dispatch(1'b1, 1'b0, 16'h0010, 8'h5A);
    vectors++;
    if ({bus.ram_en_out, bus.ram_we_out, bus.busy_out,
         bus.ram_addr_out, bus.ram_wdata_out} !==
        {3'b111, 16'h0010, 8'h5A}) begin
      miscompares++;
      $display("FAIL wr_c1 got en/we/busy=%b%b%b a=%h d=%h want 111 0010 5a",
               bus.ram_en_out, bus.ram_we_out, bus.busy_out,
               bus.ram_addr_out, bus.ram_wdata_out);
    end
    @(negedge clk);
    vectors++;
    if ({bus.write_done_out, bus.busy_out, bus.ram_en_out} !== 3'b100) begin
      miscompares++;
      $display("FAIL wr_c2 got done/busy/en=%b want 100",
               {bus.write_done_out, bus.busy_out, bus.ram_en_out});
    end
  endtask

  task automatic test_ram_read();
    sb.push_back('{rd: 1'b1, data: 8'h5A, err: 1'b0});
    dispatch(1'b0, 1'b1, 16'h0010, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      vectors++;
      if ({bus.ram_en_out, bus.ram_we_out, bus.busy_out, bus.read_valid_out}
          !== {(c == 1), 1'b0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL rd_cycle%0d got en/we/busy/rv=%b%b%b%b",
                 c, bus.ram_en_out, bus.ram_we_out,
                 bus.busy_out, bus.read_valid_out);
      end
      @(negedge clk);
    end
    vectors++;
    if ({bus.read_valid_out, bus.busy_out} !== 2'b10) begin
      miscompares++;
      $display("FAIL rd_c4 got rv/busy=%b want 10",
               {bus.read_valid_out, bus.busy_out});
    end
    // back-to-back read dispatched in the completion cycle
    sb.push_back('{rd: 1'b1, data: 8'h2D, err: 1'b0});
    dispatch(1'b0, 1'b1, 16'h0011, 8'h00);
    vectors++;
    if ({bus.ram_en_out, bus.busy_out, bus.ram_addr_out} !==
        {2'b11, 16'h0011}) begin
      miscompares++;
      $display("FAIL b2b_accept got en/busy=%b%b a=%h want 11 0011",
               bus.ram_en_out, bus.busy_out, bus.ram_addr_out);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.read_valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_valid got %b want 1", bus.read_valid_out);
    end
    @(negedge clk);
  endtask

  task automatic test_mmio_read();
    sb.push_back('{rd: 1'b1, data: 8'hC3, err: 1'b0});
    dispatch(1'b0, 1'b1, 16'hF004, 8'h00);
    vectors++;
    if ({bus.mmio_req_out, bus.mmio_we_out, bus.ram_en_out,
         bus.mmio_addr_out} !== {3'b100, 16'hF004}) begin
      miscompares++;
      $display("FAIL mm_c1 got req/we/ram_en=%b%b%b a=%h want 100 f004",
               bus.mmio_req_out, bus.mmio_we_out,
               bus.ram_en_out, bus.mmio_addr_out);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.mmio_req_out !== 1'b1) begin
      miscompares++;
      $display("FAIL mm_c3_req got %b want 1", bus.mmio_req_out);
    end
    bus.mmio_ack_in   = 1'b1;
    bus.mmio_rdata_in = 8'hC3;
    @(negedge clk);
    bus.mmio_ack_in   = 1'b0;
    bus.mmio_rdata_in = 8'h00;
    vectors++;
    if ({bus.mmio_req_out, bus.read_valid_out, bus.bus_error_out}
        !== 3'b010) begin
      miscompares++;
      $display("FAIL mm_c4 got req/rv/err=%b want 010",
               {bus.mmio_req_out, bus.read_valid_out, bus.bus_error_out});
    end
    @(negedge clk);
  endtask

  task automatic test_decode();
    sb.push_back('{rd: 1'b0, data: 8'h00, err: 1'b0});
    dispatch(1'b1, 1'b0, 16'hEFFF, 8'h11);
    vectors++;
    if ({bus.ram_en_out, bus.mmio_req_out} !== 2'b10) begin
      miscompares++;
      $display("FAIL dec_efff got ram_en/req=%b want 10",
               {bus.ram_en_out, bus.mmio_req_out});
    end
    @(negedge clk);
    sb.push_back('{rd: 1'b0, data: 8'h00, err: 1'b0});
    dispatch(1'b1, 1'b0, 16'hF000, 8'h22);
    vectors++;
    if ({bus.ram_en_out, bus.mmio_req_out, bus.mmio_we_out,
         bus.mmio_wdata_out} !== {3'b011, 8'h22}) begin
      miscompares++;
      $display("FAIL dec_f000 got ram_en/req/we=%b%b%b d=%h want 011 22",
               bus.ram_en_out, bus.mmio_req_out,
               bus.mmio_we_out, bus.mmio_wdata_out);
    end
    dispatch(1'b0, 1'b1, 16'h0020, 8'h00);
    bus.mmio_ack_in = 1'b1;
    vectors++;
    if ({bus.ram_en_out, bus.mmio_req_out, bus.mmio_addr_out}
        !== {2'b01, 16'hF000}) begin
      miscompares++;
      $display("FAIL busy_ignore got ram_en/req=%b%b a=%h want 01 f000",
               bus.ram_en_out, bus.mmio_req_out, bus.mmio_addr_out);
    end
    @(negedge clk);
    bus.mmio_ack_in = 1'b0;
    vectors++;
    if ({bus.write_done_out, bus.mmio_req_out, bus.ram_en_out}
        !== 3'b100) begin
      miscompares++;
      $display("FAIL dec_done got wd/req/ram_en=%b want 100",
               {bus.write_done_out, bus.mmio_req_out, bus.ram_en_out});
    end
    @(negedge clk);
    vectors++;
    if ({bus.busy_out, bus.ram_en_out} !== 2'b00) begin
      miscompares++;
      $display("FAIL no_extra_strobe got busy/en=%b want 00",
               {bus.busy_out, bus.ram_en_out});
    end
    // simultaneous read and write: write wins
    sb.push_back('{rd: 1'b0, data: 8'h00, err: 1'b0});
    dispatch(1'b1, 1'b1, 16'h0030, 8'h44);
    vectors++;
    if ({bus.ram_en_out, bus.ram_we_out} !== 2'b11) begin
      miscompares++;
      $display("FAIL write_wins got en/we=%b want 11",
               {bus.ram_en_out, bus.ram_we_out});
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_timeout(input logic ack_last,
                              input logic [15:0] a,
                              input logic [7:0] want);
    int  hi = 0;
    bit  done = 0;
    sb.push_back('{rd: 1'b1, data: want, err: !ack_last});
    dispatch(1'b0, 1'b1, a, 8'h00);
    for (int c = 1; c <= 80 && !done; c++) begin
      if (bus.mmio_req_out) hi++;
      if (bus.read_valid_out) begin
        done = 1;
        vectors++;
        if (c != 65 || hi != 64 || bus.bus_error_out !== !ack_last) begin
          miscompares++;
          $display("FAIL timeout_ack%0b got cyc=%0d req_cycles=%0d err=%b want 65 64 %b",
                   ack_last, c, hi, bus.bus_error_out, !ack_last);
        end
      end else begin
        if (ack_last && c == 64) begin
          bus.mmio_ack_in   = 1'b1;
          bus.mmio_rdata_in = want;
        end
        @(negedge clk);
        bus.mmio_ack_in   = 1'b0;
        bus.mmio_rdata_in = 8'h00;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_ack%0b got no completion want one", ack_last);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    dispatch(1'b0, 1'b1, 16'hF008, 8'h00);
    @(negedge clk);
    vectors++;
    if (bus.mmio_req_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre got req %b want 1", bus.mmio_req_out);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.mmio_req_out, bus.busy_out} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_async got req/busy=%b want 00",
               {bus.mmio_req_out, bus.busy_out});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus.read_valid_out, bus.write_done_out, bus.bus_error_out,
           bus.mmio_req_out, bus.busy_out} !== 5'b0) begin
        miscompares++;
        $display("FAIL rstmid_after%0d got %b want 00000", c,
                 {bus.read_valid_out, bus.write_done_out,
                  bus.bus_error_out, bus.mmio_req_out, bus.busy_out});
      end
    end
  endtask

  initial begin
    bus.addr_in           = '0;
    bus.write_data_in     = '0;
    bus.dispatch_read_in  = 1'b0;
    bus.dispatch_write_in = 1'b0;
    bus.mmio_ack_in       = 1'b0;
    bus.mmio_rdata_in     = '0;
    test_reset();
    test_ram_write();
    test_ram_read();
    test_mmio_read();
    test_decode();
    test_timeout(1'b0, 16'hFFFF, 8'hFF);
    test_timeout(1'b1, 16'hF010, 8'h77);
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
